inst_encoder_loader: RTL and testbench
======================================

// Module: inst_encoder_loader
// PURPOSE
//  Write-side counterpart of the CPU Control decoder: accepts instruction requests (R-type or addi
//  fields), encodes each into a 32-bit MIPS word and writes it into instruction memory at sequential
//  word addresses. Sits between the testbench/boot source and Instruction_Memory. Requests are
//  buffered in a small FIFO so memory stalls (mem_ack_i low) do not stall the request source.
// PARAMETERS
//  ADDR_W     8   word-address width; capacity = 2**ADDR_W words
//  DEPTH      4   request FIFO entries (power of 2, >=2)
//  BASE_ADDR  0   first byte address written per session (word aligned)
// PORTS
//  clk_i        in   1       clock, all logic on rising edge
//  rst_i        in   1       synchronous, active-low reset
//  start_i      in   1       begin a load session (honoured only in IDLE or DONE)
//  req_valid_i  in   1       request present
//  req_ready_o  out  1       request accepted when valid&ready on a clock edge
//  req_type_i   in   1       0 = R-type, 1 = addi
//  req_rs_i     in   5       rs field
//  req_rt_i     in   5       rt field
//  req_rd_i     in   5       rd field (R-type only)
//  req_funct_i  in   6       funct field (R-type only)
//  req_imm_i    in   16      immediate (addi only)
//  req_last_i   in   1       marks final instruction of the session
//  mem_we_o     out  1       write strobe to instruction memory
//  mem_addr_o   out  32      byte address, word aligned
//  mem_data_o   out  32      encoded instruction word
//  mem_ack_i    in   1       memory accepted the write this cycle
//  busy_o       out  1       state is LOAD or DRAIN
//  done_o       out  1       session complete (level, held until start_i or reset)
//  err_o        out  1       address space exhausted before last (level, cleared by start_i/reset)
//  count_o      out  ADDR_W+1  words written this session
// BEHAVIOUR
//  Reset (rst_i=0 at edge): state IDLE; FIFO emptied; all outputs 0; mem_addr_o=BASE_ADDR.
//  Encoding (registered at FIFO push): R-type = {6'b000000, rs, rt, rd, 5'b00000, funct};
//   addi = {6'b001000, rs, rt, imm}. Opcode bit 29 is the sole R-type/addi discriminator downstream.
//  FSM: IDLE -start_i-> LOAD; LOAD -last entry pushed-> DRAIN; DRAIN -FIFO empty after final ack->
//   DONE; LOAD/DRAIN -write of word 2**ADDR_W-1 acked and not last-> DONE with err_o=1;
//   DONE -start_i-> LOAD. start_i in LOAD/DRAIN is ignored.
//  start_i accepted: mem_addr_o<=BASE_ADDR, count_o<=0, done_o<=0, err_o<=0, FIFO emptied.
//  req_ready_o = (state==LOAD) && !fifo_full; depends on current occupancy only (no same-cycle
//   pop credit). Requests offered outside LOAD are not consumed.
//  Write side: mem_we_o=1 whenever FIFO non-empty in LOAD/DRAIN; mem_data_o=head entry. Data and
//   address held stable until mem_ack_i=1; on ack: pop, mem_addr_o+=4, count_o+=1. mem_ack_i while
//   mem_we_o=0 is ignored.
//  Latency: request pushed at edge N into empty FIFO -> mem_we_o=1 in cycle N+1; back-to-back acks
//   give one word per cycle.
//  Simultaneous push and pop: both take effect; occupancy unchanged.
//  Address wrap: never wraps; after word 2**ADDR_W-1 is acked without last, FIFO flushed, err_o=1.
//  Reset mid-session: pending FIFO contents discarded; mem_we_o low from next cycle; memory content
//   already written is not rolled back.
// TESTING
//  R-type rs=1,rt=2,rd=3,funct=0x20 after start -> one write addr 0x0, data 0x00221820, done_o=1.
//  addi rs=0,rt=8,imm=0xFFFF,last=1 -> data 0x2008FFFF at addr 0x0; count_o=1; busy_o=0 after ack.
//  6 back-to-back requests, mem_ack_i low 10 cycles -> ready drops after 4 pushes, mem_* stable,
//   then addrs 0x0..0x14 in order, count_o=6.
//  ADDR_W=2, 5 requests none last -> 4 writes (0x0..0xC), err_o=1, 5th never written, ready=0.
//  rst_i low during DRAIN with 3 entries queued -> next cycle mem_we_o=0, state IDLE, count_o=0.
//  start_i pulsed during LOAD -> ignored; addresses continue incrementing, no reset of count_o.

Source files
------------

// File: rtl/inst_encoder_loader.sv
// Encodes R-type / addi requests into 32-bit MIPS words and writes them to instruction memory
// at sequential word addresses, buffering requests in a small FIFO to absorb memory stalls.
module inst_encoder_loader #(
  parameter int          ADDR_W    = 8,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_type_i,
  input  logic [4:0]        req_rs_i,
  input  logic [4:0]        req_rt_i,
  input  logic [4:0]        req_rd_i,
  input  logic [5:0]        req_funct_i,
  input  logic [15:0]       req_imm_i,
  input  logic              req_last_i,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [31:0]       mem_data_o,
  input  logic              mem_ack_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_OCC = (PTR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [32:0]        r_fifo [DEPTH];   // {last, encoded word}
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_occ;
  logic [31:0]        r_addr;
  logic [ADDR_W:0]    r_count;
  logic               r_done;
  logic               r_err;

  logic               w_empty;
  logic               w_full;
  logic               w_active;
  logic               w_we;
  logic               w_push;
  logic               w_pop;
  logic               w_start;
  logic               w_head_last;
  logic               w_finish;
  logic               w_overflow;
  logic [31:0]        w_encoded;
  logic [32:0]        w_head;

  assign w_empty     = (r_occ == '0);
  assign w_full      = (r_occ == FULL_OCC);
  assign w_active    = (r_state == S_LOAD) || (r_state == S_DRAIN);
  assign w_we        = w_active && !w_empty;
  assign w_push      = (r_state == S_LOAD) && !w_full && req_valid_i;
  assign w_pop       = w_we && mem_ack_i;
  assign w_start     = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_head      = r_fifo[r_rd_ptr];
  assign w_head_last = w_head[32];
  assign w_finish    = w_pop && w_head_last;
  // Acking the top word of the address space without the session's last entry ends in error.
  assign w_overflow  = w_pop && !w_head_last && (r_count == LAST_IDX);

  assign w_encoded = req_type_i
                   ? {6'b001000, req_rs_i, req_rt_i, req_imm_i}
                   : {6'b000000, req_rs_i, req_rt_i, req_rd_i, 5'b00000, req_funct_i};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_LOAD;
      S_LOAD: begin
        if (w_overflow || w_finish)     w_state_next = S_DONE;
        else if (w_push && req_last_i)  w_state_next = S_DRAIN;
      end
      S_DRAIN: if (w_overflow || w_finish || w_empty) w_state_next = S_DONE;
      S_DONE:  if (w_start) w_state_next = S_LOAD;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {req_last_i, w_encoded};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_addr   <= BASE_ADDR;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_occ    <= '0;
        r_addr   <= BASE_ADDR;
        r_count  <= '0;
        r_done   <= 1'b0;
        r_err    <= 1'b0;
      end else if (w_overflow) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_occ    <= '0;
        r_addr   <= r_addr + 32'd4;
        r_count  <= r_count + 1'b1;
        r_done   <= 1'b1;
        r_err    <= 1'b1;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_addr   <= r_addr + 32'd4;
          r_count  <= r_count + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_occ <= r_occ + 1'b1;
          2'b01:   r_occ <= r_occ - 1'b1;
          default: r_occ <= r_occ;
        endcase
        if (w_active && (w_state_next == S_DONE)) r_done <= 1'b1;
      end
    end
  end

  assign req_ready_o = (r_state == S_LOAD) && !w_full;
  assign mem_we_o    = w_we;
  assign mem_addr_o  = r_addr;
  assign mem_data_o  = w_we ? w_head[31:0] : 32'h0;
  assign busy_o      = w_active;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign count_o     = r_count;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Randomized and directed bench for inst_encoder_loader against a queue-based reference model.
module tb_inst_encoder_loader;

  localparam int          ADDR_W = 3;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          CAP    = 1 << ADDR_W;

  logic              clk_i;
  logic              rst_i;
  logic              start_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_type_i;
  logic [4:0]        req_rs_i;
  logic [4:0]        req_rt_i;
  logic [4:0]        req_rd_i;
  logic [5:0]        req_funct_i;
  logic [15:0]       req_imm_i;
  logic              req_last_i;
  logic              mem_we_o;
  logic [31:0]       mem_addr_o;
  logic [31:0]       mem_data_o;
  logic              mem_ack_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [ADDR_W:0]   count_o;

  inst_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_type_i(req_type_i),
    .req_rs_i(req_rs_i), .req_rt_i(req_rt_i), .req_rd_i(req_rd_i),
    .req_funct_i(req_funct_i), .req_imm_i(req_imm_i), .req_last_i(req_last_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .count_o(count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] word;
    bit          last;
  } ent_t;

  ent_t q[$];
  bit   m_active;
  bit   m_got_last;
  bit   m_done;
  bit   m_err;
  int   m_written;
  int   m_pushed;
  int   n_tests;
  int   n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc();
    logic [31:0] w;
    if (req_type_i)
      w = 32'h2000_0000 + (32'(req_rs_i) << 21) + (32'(req_rt_i) << 16) + 32'(req_imm_i);
    else
      w = (32'(req_rs_i) << 21) + (32'(req_rt_i) << 16) + (32'(req_rd_i) << 11) + 32'(req_funct_i);
    return w;
  endfunction

  task automatic rand_fields(input bit last);
    req_type_i  = 1'($urandom);
    req_rs_i    = 5'($urandom);
    req_rt_i    = 5'($urandom);
    req_rd_i    = 5'($urandom);
    req_funct_i = 6'($urandom);
    req_imm_i   = 16'($urandom);
    req_last_i  = last;
  endtask

  // Inputs are already set; compare outputs, advance the model across the coming edge.
  task automatic tick();
    bit   exp_ready;
    bit   exp_we;
    ent_t e;
    #1;
    exp_ready = m_active && !m_got_last && (q.size() < DEPTH);
    exp_we    = m_active && (q.size() > 0);
    chk("ready", 32'(req_ready_o), 32'(exp_ready));
    chk("we", 32'(mem_we_o), 32'(exp_we));
    chk("addr", mem_addr_o, BASE + 32'(4 * m_written));
    chk("count", 32'(count_o), 32'(m_written));
    chk("busy", 32'(busy_o), 32'(m_active));
    chk("err", 32'(err_o), 32'(m_err));
    if (!m_err) chk("done", 32'(done_o), 32'(m_done));
    if (exp_we) chk("data", mem_data_o, q[0].word);
    if (!rst_i) begin
      q.delete();
      m_active = 0; m_got_last = 0; m_done = 0; m_err = 0; m_written = 0;
    end else if (start_i && !m_active) begin
      q.delete();
      m_active = 1; m_got_last = 0; m_done = 0; m_err = 0; m_written = 0;
    end else if (m_active) begin
      if (exp_we && mem_ack_i) begin
        e = q.pop_front();
        $display("[TB] write addr=%h data=%h last=%0d", mem_addr_o, mem_data_o, e.last);
        m_written++;
        if (e.last) begin
          m_active = 0; m_done = 1;
        end else if (m_written == CAP) begin
          m_active = 0; m_done = 1; m_err = 1;
          q.delete();
        end
      end
      if (m_active && exp_ready && req_valid_i) begin
        e.word = enc();
        e.last = req_last_i;
        q.push_back(e);
        m_pushed++;
        if (req_last_i) m_got_last = 1;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic start_session();
    start_i = 1'b1; req_valid_i = 1'b0; mem_ack_i = 1'b0;
    tick();
    start_i = 1'b0;
    m_pushed = 0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; m_pushed = 0;
    rst_i = 1'b0; start_i = 1'b0; req_valid_i = 1'b0; mem_ack_i = 1'b0;
    rand_fields(1'b0);
    repeat (2) @(negedge clk_i);
    tick();
    rst_i = 1'b1;
    tick();

    // R-type rs=1 rt=2 rd=3 funct=0x20, last
    start_session();
    req_type_i = 1'b0; req_rs_i = 5'd1; req_rt_i = 5'd2; req_rd_i = 5'd3;
    req_funct_i = 6'h20; req_last_i = 1'b1; req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    #1;
    chk("rtype_latency_we", 32'(mem_we_o), 32'd1);
    chk("rtype_word", mem_data_o, 32'h0022_1820);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    #1;
    chk("rtype_done", 32'(done_o), 32'd1);

    // addi rs=0 rt=8 imm=0xFFFF, last
    start_session();
    req_type_i = 1'b1; req_rs_i = 5'd0; req_rt_i = 5'd8; req_imm_i = 16'hFFFF;
    req_last_i = 1'b1; req_valid_i = 1'b1; mem_ack_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    #1;
    chk("addi_word", mem_data_o, 32'h2008_FFFF);
    tick();
    #1;
    chk("addi_count", 32'(count_o), 32'd1);
    chk("addi_busy", 32'(busy_o), 32'd0);

    // six back-to-back requests with memory stalled for 10 cycles
    start_session();
    for (int c = 0; c < 30; c++) begin
      mem_ack_i   = (c >= 10);
      req_valid_i = (m_pushed < 6);
      rand_fields(m_pushed == 5);
      if (c == 8) chk("stall_ready_low", 32'(req_ready_o), 32'd0);
      tick();
    end
    req_valid_i = 1'b0;
    #1;
    chk("b2b_count", 32'(count_o), 32'd6);
    chk("b2b_done", 32'(done_o), 32'd1);

    // address space exhaustion: CAP+1 requests, none marked last
    start_session();
    mem_ack_i = 1'b1;
    for (int c = 0; c < 25; c++) begin
      req_valid_i = (m_pushed < CAP + 1);
      rand_fields(1'b0);
      tick();
    end
    req_valid_i = 1'b0;
    #1;
    chk("ovf_err", 32'(err_o), 32'd1);
    chk("ovf_count", 32'(count_o), 32'(CAP));
    chk("ovf_ready", 32'(req_ready_o), 32'd0);
    chk("ovf_we", 32'(mem_we_o), 32'd0);

    // reset during drain with three entries queued
    start_session();
    for (int c = 0; c < 6; c++) begin
      req_valid_i = (m_pushed < 4);
      rand_fields(m_pushed == 3);
      tick();
    end
    req_valid_i = 1'b0; mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0; rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    #1;
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);

    // start pulsed mid-session is ignored
    start_session();
    mem_ack_i = 1'b1;
    for (int c = 0; c < 15; c++) begin
      start_i     = (c == 3);
      req_valid_i = (m_pushed < 4);
      rand_fields(m_pushed == 3);
      tick();
    end
    start_i = 1'b0; req_valid_i = 1'b0;
    #1;
    chk("start_ignored_count", 32'(count_o), 32'd4);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      rst_i       = ($urandom_range(0, 299) != 0);
      start_i     = ($urandom_range(0, 19) == 0);
      req_valid_i = ($urandom_range(0, 2) != 0);
      rand_fields($urandom_range(0, 9) == 0);
      mem_ack_i   = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
